// File: rtl/square_seq.sv
// rtl/square_seq.sv - sequential shift-add Q8.8 squarer with saturated integer result
//
// Purpose:
//   Squares a Q(W-FRAC).FRAC root value one multiplier bit per clock and
//   returns the full Q(2W-2FRAC).(2FRAC) product plus a saturated integer part.
//   FSM: IDLE -> CALC (W cycles) -> DONE (1 cycle) -> IDLE.
//
// Ports:
//   clk      in   1        rising-edge clock
//   rst_n    in   1        asynchronous active-low reset
//   start    in   1        request, accepted only while ready=1
//   root_in  in   W        operand, sampled on the accepting edge
//   ready    out  1        high in IDLE only
//   done     out  1        one-cycle pulse, results updated this cycle
//   square   out  2*W      root_in*root_in
//   sq_int   out  OUT_W    integer part of square, saturated
//   ovf      out  1        integer part (after optional rounding) exceeds OUT_W bits
//
// Configuration:
//   SQUARE_ROUND_EN  defined: integer part rounded half up; undefined: truncated.

module square_seq #(
    parameter int W     = 16,
    parameter int FRAC  = 8,
    parameter int OUT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [W-1:0]         root_in,
    output logic                 ready,
    output logic                 done,
    output logic [2*W-1:0]       square,
    output logic [OUT_W-1:0]     sq_int,
    output logic                 ovf
);

    localparam int IW = 2*W - 2*FRAC;
    localparam int CW = ($clog2(W) > 0) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    // Largest integer representable in sq_int, widened to the adjusted-ipart width.
    localparam logic [IW:0] SAT_MAX = {{(IW+1-OUT_W){1'b0}}, {OUT_W{1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [2*W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]     mult_q, mult_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*W-1:0]   square_q, square_d;
    logic [OUT_W-1:0] sq_int_q, sq_int_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic load_op;
    logic step;
    logic finish;

    logic [IW-1:0] ipart;
    logic [IW:0]   ipart_adj;
    logic          ovf_c;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_CALC;
            // No early exit when mult reaches zero: latency is data-independent.
            ST_CALC: if (cnt_q == CNT_LAST) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ready   = 1'b0;
        load_op = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready   = 1'b1;
                load_op = start;
            end
            ST_CALC: step   = 1'b1;
            ST_DONE: finish = 1'b1;
            default: ;
        endcase
    end

    // ---------------- result formatting ----------------
    always_comb begin
        ipart = acc_q[2*W-1:2*FRAC];
`ifdef SQUARE_ROUND_EN
        // Round half up on the first dropped fraction bit; carry may push past SAT_MAX.
        ipart_adj = {1'b0, ipart} + {{IW{1'b0}}, acc_q[2*FRAC-1]};
`else
        ipart_adj = {1'b0, ipart};
`endif
        ovf_c = (ipart_adj > SAT_MAX);
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        mcand_d  = mcand_q;
        mult_d   = mult_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        square_d = square_q;
        sq_int_d = sq_int_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        if (load_op) begin
            mcand_d = {{W{1'b0}}, root_in};
            mult_d  = root_in;
            acc_d   = '0;
            cnt_d   = '0;
        end

        if (step) begin
            if (mult_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d = mcand_q << 1;
            mult_d  = mult_q >> 1;
            cnt_d   = cnt_q + CW'(1);
        end

        if (finish) begin
            square_d = acc_q;
            sq_int_d = ovf_c ? {OUT_W{1'b1}} : ipart_adj[OUT_W-1:0];
            ovf_d    = ovf_c;
            done_d   = 1'b1;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mult_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            square_q <= '0;
            sq_int_q <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mult_q   <= mult_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            square_q <= square_d;
            sq_int_q <= sq_int_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign done   = done_q;
    assign square = square_q;
    assign sq_int = sq_int_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_square_seq.sv
// tb/tb_square_seq.sv - randomized self-checking bench for square_seq

module tb_square_seq;

    localparam int W     = 16;
    localparam int FRAC  = 8;
    localparam int OUT_W = 8;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [W-1:0]    root_in;
    logic            ready;
    logic            done;
    logic [2*W-1:0]  square;
    logic [OUT_W-1:0] sq_int;
    logic            ovf;

    int n_total;
    int n_pass;

    // reference model state
    bit              busy;
    int              remaining;
    longint unsigned p_sq, m_sq;
    int              p_int, m_int;
    bit              p_ovf, m_ovf;

    square_seq #(.W(W), .FRAC(FRAC), .OUT_W(OUT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .root_in (root_in),
        .ready   (ready),
        .done    (done),
        .square  (square),
        .sq_int  (sq_int),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Arithmetic definition of the result for one operand.
    task automatic model_calc(input logic [W-1:0] r, output longint unsigned sq,
                              output int si, output bit ov);
        longint unsigned ip;
        sq = longint'(r) * longint'(r);
        ip = sq >> (2*FRAC);
`ifdef SQUARE_ROUND_EN
        ip = ip + ((sq >> (2*FRAC-1)) & 1);
`endif
        ov = (ip > ((1 << OUT_W) - 1));
        si = ov ? ((1 << OUT_W) - 1) : int'(ip);
    endtask

    // Every-cycle compare against the model; sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy  = 0;
            m_sq  = 0;
            m_int = 0;
            m_ovf = 0;
            chk("rst_ready", ready, 1);
            chk("rst_done", done, 0);
            chk("rst_square", square, 0);
            chk("rst_sq_int", sq_int, 0);
            chk("rst_ovf", ovf, 0);
        end else begin
            bit exp_done;
            exp_done = 0;
            if (busy) begin
                remaining--;
                if (remaining == 0) begin
                    busy     = 0;
                    exp_done = 1;
                    m_sq     = p_sq;
                    m_int    = p_int;
                    m_ovf    = p_ovf;
                end
            end
            chk("done", done, exp_done);
            chk("ready", ready, !busy);
            chk("square", square, m_sq);
            chk("sq_int", sq_int, m_int);
            chk("ovf", ovf, m_ovf);
            if (!busy && start) begin
                busy      = 1;
                remaining = W + 2;
                model_calc(root_in, p_sq, p_int, p_ovf);
            end
        end
    end

    // One operation; optionally pins DUT results and latency to literals.
    task automatic do_op(input logic [W-1:0] r, input bit lit,
                         input longint unsigned e_sq, input int e_int, input bit e_ovf,
                         input string tag);
        bit got;
        int lat;
        got = 0;
        lat = 0;
        @(posedge clk); #1;
        start   = 1'b1;
        root_in = r;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                start   = 1'b0;
                root_in = W'($urandom);
            end
            @(negedge clk);
            if (done) begin
                got = 1;
                lat = i;
                break;
            end
        end
        chk({tag, "_done_seen"}, got, 1);
        if (lit) begin
            chk({tag, "_latency"}, lat, W + 1);
            chk({tag, "_square"}, square, e_sq);
            chk({tag, "_sq_int"}, sq_int, e_int);
            chk({tag, "_ovf"}, ovf, e_ovf);
        end
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        busy    = 0;
        start   = 1'b0;
        root_in = '0;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

`ifdef SQUARE_ROUND_EN
        do_op(16'h0BCA, 1, 32'h008AFB64, 139, 0, "t1");
        do_op(16'h0FFF, 1, 32'h00FFE001, 255, 1, "t3");
`else
        do_op(16'h0BCA, 1, 32'h008AFB64, 138, 0, "t1");
        do_op(16'h0FFF, 1, 32'h00FFE001, 255, 0, "t3");
`endif
        do_op(16'h0F00, 1, 32'h00E10000, 225, 0, "t2");
        do_op(16'h1000, 1, 32'h01000000, 255, 1, "t4a");
        do_op(16'hFFFF, 1, 64'hFFFE0001, 255, 1, "t4b");
        do_op(16'h0100, 1, 32'h00010000, 1,   0, "one");

        // random operands: small roots and full range, random gaps
        for (int n = 0; n < 30; n++) begin
            logic [W-1:0] r;
            r = (n % 2 == 0) ? W'($urandom_range(0, 16'h1100)) : W'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            do_op(r, 0, 0, 0, 0, "rnd");
        end

        // start held high, operand changing every cycle
        @(posedge clk); #1;
        start = 1'b1;
        for (int i = 0; i < 80; i++) begin
            root_in = W'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (W + 4) @(posedge clk);

        // zero operand, then reset mid-CALC
        do_op(16'h0000, 1, 0, 0, 0, "t6");
        @(posedge clk); #1;
        start   = 1'b1;
        root_in = 16'h1234;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (W + 6) @(negedge clk);
        chk("abort_ready", ready, 1);
        chk("abort_square", square, 0);
        chk("abort_sq_int", sq_int, 0);

        // unit still works after the abort
        do_op(16'h0200, 1, 32'h00040000, 4, 0, "post");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
